instr_sequencer: RTL and testbench

//  Multi-cycle control sequencer for the 9-bit-instruction core: steps each instruction through

---
 rtl/seq_pkg.sv | 24 ++
 rtl/seq_wait_counter.sv | 33 +++
 rtl/instr_sequencer.sv | 178 +++++++++++++++++
 tb/tb_instr_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the multi-cycle instruction sequencer.
//   state_t   : sequencer phase encoding
//   ALUOP_MUL : decoder ALUOp value that selects the multi-cycle multiplier
//   HALT_CODE : instruction word that stops the core
//   max_lat() : larger of two latencies, used to size the wait counter
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    MEM   = 3'd3,
    WB    = 3'd4,
    HALT  = 3'd5
  } state_t;

  localparam logic [3:0] ALUOP_MUL = 4'd8;
  localparam logic [8:0] HALT_CODE = 9'h1FF;

  function automatic int unsigned max_lat(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seq_wait_counter.sv
// Phase wait counter shared by EXEC and MEM.
// Counts 0,1,2,... from the cycle after a clear; o_last_c flags the cycle
// whose count equals i_len-1, i.e. the final cycle of an i_len-cycle phase.
//   clk, rst_n : clock, async active-low reset
//   i_clr      : restart the count at 0 on the next edge
//   i_len      : phase length in cycles (>=1), combinational select by the owner
//   o_last_c   : current cycle is the last of the phase (combinational)
module seq_wait_counter #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic [CNT_W-1:0] i_len,
  output logic             o_last_c
);

  logic [CNT_W-1:0] r_cnt;

  // Count register: cleared whenever the owner is not holding a phase open.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_last_c = (r_cnt == (i_len - CNT_W'(1)));

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer for the 9-bit-instruction core.
// Steps each instruction through FETCH/EXEC/MEM/WB, owns PC and IR, and
// gates the decoder's write strobes so they only fire in MEM/WB.
//   clk, rst_n        : clock, async active-low reset
//   i_start           : begin execution at PC 0 (IDLE/HALT only)
//   i_instr           : instruction ROM data at o_pc
//   i_branch .. i_alu_op : combinational decoder outputs driven from o_ir
//   i_take_branch     : branch condition
//   i_target          : branch target
//   o_pc, o_ir        : program counter, latched instruction
//   o_reg_we, o_mem_we, o_mem_re : gated strobes (registered)
//   o_busy, o_done    : executing / halted (registered)
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned PC_W    = 10,
  parameter int unsigned MCODE_W = 9,
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [MCODE_W-1:0] i_instr,
  input  logic               i_branch,
  input  logic               i_mem_to_reg,
  input  logic               i_mem_write,
  input  logic               i_reg_write,
  input  logic [3:0]         i_alu_op,
  input  logic               i_take_branch,
  input  logic [PC_W-1:0]    i_target,
  output logic [PC_W-1:0]    o_pc,
  output logic [MCODE_W-1:0] o_ir,
  output logic               o_reg_we,
  output logic               o_mem_we,
  output logic               o_mem_re,
  output logic               o_busy,
  output logic               o_done
);

  localparam int unsigned MAX_LAT = max_lat(MEM_LAT, MUL_LAT);
  localparam int unsigned CNT_W   = $clog2(MAX_LAT) + 1;

  state_t             r_state;
  logic [PC_W-1:0]    r_pc;
  logic [MCODE_W-1:0] r_ir;
  logic               r_reg_we;
  logic               r_mem_we;
  logic               r_mem_re;
  logic               r_busy;
  logic               r_done;
  // Set one edge after reset release so a start coinciding with release is ignored.
  logic               r_armed;

  logic               w_is_mul;
  logic               w_cnt_last;
  logic [CNT_W-1:0]   w_cnt_len;
  logic               w_exec_exit;
  logic               w_mem_exit;
  logic               w_cnt_clr;
  logic               w_start_ok;
  logic               w_is_mem;
  logic [PC_W-1:0]    w_pc_inc;

  assign w_is_mul    = (i_alu_op == ALUOP_MUL);
  assign w_cnt_len   = (r_state == MEM) ? CNT_W'(MEM_LAT) : CNT_W'(MUL_LAT);
  assign w_exec_exit = !w_is_mul || w_cnt_last;
  assign w_mem_exit  = w_cnt_last;
  // Keep counting only while EXEC/MEM is being held open; any other cycle rearms at 0.
  assign w_cnt_clr   = !(((r_state == EXEC) && !w_exec_exit) ||
                         ((r_state == MEM)  && !w_mem_exit));
  assign w_start_ok  = i_start && r_armed;
  assign w_is_mem    = i_mem_write || i_mem_to_reg;
  assign w_pc_inc    = r_pc + PC_W'(1);

  seq_wait_counter #(
    .CNT_W (CNT_W)
  ) u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_cnt_clr),
    .i_len    (w_cnt_len),
    .o_last_c (w_cnt_last)
  );

  // Sequencer FSM; strobes/status are registered alongside the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_pc     <= '0;
      r_ir     <= '0;
      r_reg_we <= 1'b0;
      r_mem_we <= 1'b0;
      r_mem_re <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_armed  <= 1'b0;
    end else begin
      r_armed  <= 1'b1;
      r_reg_we <= 1'b0;
      r_mem_we <= 1'b0;
      r_mem_re <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start_ok) begin
            r_pc    <= '0;
            r_state <= FETCH;
            r_busy  <= 1'b1;
          end
        end
        FETCH: begin
          r_ir <= i_instr;
          if (i_instr == MCODE_W'(HALT_CODE)) begin
            r_state <= HALT;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= EXEC;
          end
        end
        EXEC: begin
          if (w_exec_exit) begin
            if (i_branch) begin
              r_pc    <= i_take_branch ? i_target : w_pc_inc;
              r_state <= FETCH;
            end else if (w_is_mem) begin
              r_state  <= MEM;
              r_mem_we <= i_mem_write;  // first MEM cycle only
              r_mem_re <= i_mem_to_reg;
            end else begin
              r_state  <= WB;
              r_reg_we <= i_reg_write;
            end
          end
        end
        MEM: begin
          if (w_mem_exit) begin
            if (i_mem_to_reg) begin
              r_state  <= WB;
              r_reg_we <= i_reg_write;
            end else begin
              r_pc    <= w_pc_inc;
              r_state <= FETCH;
            end
          end else begin
            r_mem_re <= i_mem_to_reg;
          end
        end
        WB: begin
          r_pc    <= w_pc_inc;
          r_state <= FETCH;
        end
        HALT: begin
          if (w_start_ok) begin
            r_pc    <= '0;
            r_state <= FETCH;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_pc     = r_pc;
  assign o_ir     = r_ir;
  assign o_reg_we = r_reg_we;
  assign o_mem_we = r_mem_we;
  assign o_mem_re = r_mem_re;
  assign o_busy   = r_busy;
  assign o_done   = r_done;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer with a toy ROM and decoder.
// Opcode in ir[8:6]: 0 ALU+wr, 1 MUL+wr, 2 store, 3 load+wr, 4 branch taken,
// 5 branch not taken, 6 ALU no wr. Target LUT: ir[5:0]==63 -> 0x3FF, else ir[5:0].
module tb_instr_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [8:0] instr;
  logic       branch, mem_to_reg, mem_write, reg_write, take_branch;
  logic [3:0] alu_op;
  logic [9:0] target;
  logic [9:0] pc;
  logic [8:0] ir;
  logic       reg_we, mem_we, mem_re, busy, done;

  logic [8:0] rom [1024];

  int n_checks;
  int n_fail;

  instr_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (start),
    .i_instr       (instr),
    .i_branch      (branch),
    .i_mem_to_reg  (mem_to_reg),
    .i_mem_write   (mem_write),
    .i_reg_write   (reg_write),
    .i_alu_op      (alu_op),
    .i_take_branch (take_branch),
    .i_target      (target),
    .o_pc          (pc),
    .o_ir          (ir),
    .o_reg_we      (reg_we),
    .o_mem_we      (mem_we),
    .o_mem_re      (mem_re),
    .o_busy        (busy),
    .o_done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb instr = rom[pc];

  // Toy decoder driven from the latched instruction
  always_comb begin
    branch      = 1'b0;
    mem_to_reg  = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    take_branch = 1'b0;
    alu_op      = 4'd0;
    case (ir[8:6])
      3'd0: reg_write = 1'b1;
      3'd1: begin alu_op = 4'd8; reg_write = 1'b1; end
      3'd2: mem_write = 1'b1;
      3'd3: begin mem_to_reg = 1'b1; reg_write = 1'b1; end
      3'd4: begin branch = 1'b1; take_branch = 1'b1; end
      3'd5: branch = 1'b1;
      3'd6: alu_op = 4'd1;
      default: ;
    endcase
    target = (ir[5:0] == 6'd63) ? 10'h3FF : {4'd0, ir[5:0]};
  end

  function automatic logic [8:0] jmp_to(input logic [9:0] t);
    return (t == 10'h3FF) ? 9'h13F : {3'd4, t[5:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    start = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    string      name;
    logic [9:0] pc_t;
    logic [8:0] op;
    int         cycles;
    int         n_reg;
    int         n_mwe;
    int         n_mre;
    logic [9:0] next_pc;
  } vec_t;

  vec_t vecs[8];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 1024; i++) rom[i] = 9'h000;

    vecs[0] = '{"alu",      10'h005, 9'h000, 3, 1, 0, 0, 10'h006};
    vecs[1] = '{"store",    10'h003, 9'h080, 4, 0, 1, 0, 10'h004};
    vecs[2] = '{"load",     10'h007, 9'h0C0, 5, 1, 0, 2, 10'h008};
    vecs[3] = '{"mul",      10'h009, 9'h040, 5, 1, 0, 0, 10'h00A};
    vecs[4] = '{"br_taken", 10'h010, 9'h120, 2, 0, 0, 0, 10'h020};
    vecs[5] = '{"br_wrap",  10'h3FF, 9'h140, 2, 0, 0, 0, 10'h000};
    vecs[6] = '{"alu_nowr", 10'h011, 9'h180, 3, 0, 0, 0, 10'h012};
    vecs[7] = '{"alu_wrap", 10'h3FF, 9'h000, 3, 1, 0, 0, 10'h000};

    // Reset state
    start = 1'b0;
    rst_n = 1'b0;
    #12;
    check("rst_pc",   32'(pc), 32'h0);
    check("rst_ir",   32'(ir), 32'h0);
    check("rst_strb", 32'({reg_we, mem_we, mem_re}), 32'h0);
    check("rst_stat", 32'({busy, done}), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table: jump from PC 0 to the test PC, then time the instruction there.
    // start is held high throughout to show it is ignored while busy.
    for (int v = 0; v < 8; v++) begin
      int cyc, nr, nw, nre;
      bit reached;
      rom[0] = jmp_to(vecs[v].pc_t);
      rom[vecs[v].pc_t] = vecs[v].op;
      do_reset();
      start = 1'b1;
      reached = 1'b0;
      for (int k = 0; k < 10 && !reached; k++) begin
        @(negedge clk);
        if (pc == vecs[v].pc_t) reached = 1'b1;
      end
      check({vecs[v].name, "_reach"}, 32'(reached), 32'h1);
      cyc = 0; nr = 0; nw = 0; nre = 0;
      while (reached && pc == vecs[v].pc_t && cyc < 20) begin
        cyc++;
        if (cyc == 2) check({vecs[v].name, "_ir"}, 32'(ir), 32'(vecs[v].op));
        if (reg_we) nr++;
        if (mem_we) nw++;
        if (mem_re) nre++;
        if (cyc == vecs[v].cycles && vecs[v].n_reg != 0)
          check({vecs[v].name, "_we_last"}, 32'(reg_we), 32'h1);
        @(negedge clk);
      end
      check({vecs[v].name, "_cycles"}, 32'(cyc),  32'(vecs[v].cycles));
      check({vecs[v].name, "_reg_we"}, 32'(nr),   32'(vecs[v].n_reg));
      check({vecs[v].name, "_mem_we"}, 32'(nw),   32'(vecs[v].n_mwe));
      check({vecs[v].name, "_mem_re"}, 32'(nre),  32'(vecs[v].n_mre));
      check({vecs[v].name, "_pc"},     32'(pc),   32'(vecs[v].next_pc));
      check({vecs[v].name, "_busy"},   32'(busy), 32'h1);
      start = 1'b0;
      rom[vecs[v].pc_t] = 9'h000;
    end

    // Async reset in the middle of WB drops the strobe at once
    begin
      bit seen;
      rom[0] = jmp_to(10'h005);
      do_reset();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 12 && !seen; k++) begin
        if (reg_we) seen = 1'b1;
        else @(negedge clk);
      end
      check("wb_seen", 32'(seen), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check("midwb_strb", 32'({reg_we, mem_we, mem_re}), 32'h0);
      check("midwb_stat", 32'({busy, done}), 32'h0);
      check("midwb_pc",   32'(pc), 32'h0);
      @(negedge clk);
      // Start together with reset release is ignored
      rst_n = 1'b1;
      start = 1'b1;
      @(negedge clk);
      check("rel_start_ign", 32'(busy), 32'h0);
      @(negedge clk);
      check("start_busy", 32'(busy), 32'h1);
      check("start_pc",   32'(pc), 32'h0);
      start = 1'b0;
      @(negedge clk);
      check("start_ir", 32'(ir), 32'(jmp_to(10'h005)));
    end

    // HALT: done held, pc held, restart from 0
    begin
      bit halted;
      rom[0] = jmp_to(10'h012);
      rom[10'h012] = 9'h1FF;
      do_reset();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      halted = 1'b0;
      for (int k = 0; k < 12 && !halted; k++) begin
        if (done) halted = 1'b1;
        else @(negedge clk);
      end
      check("halt_seen", 32'(halted), 32'h1);
      check("halt_busy", 32'(busy), 32'h0);
      check("halt_ir",   32'(ir), 32'h1FF);
      repeat (3) @(negedge clk);
      check("halt_held", 32'(done), 32'h1);
      check("halt_pc",   32'(pc), 32'h012);
      check("halt_strb", 32'({reg_we, mem_we, mem_re}), 32'h0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("restart_done", 32'(done), 32'h0);
      check("restart_busy", 32'(busy), 32'h1);
      check("restart_pc",   32'(pc), 32'h0);
      @(negedge clk);
      check("restart_ir", 32'(ir), 32'(jmp_to(10'h012)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
